// File: rtl/alien_fleet_if.sv
// Bus bundle between the invader formation and its neighbours (player, renderer, controller).
// Carries the bullet probe inputs, wave controls and the formation status outputs.
interface alien_fleet_if #(
   parameter int ROWS = 4,
   parameter int COLS = 8
);
   // bullet_x/bullet_y are only meaningful while bullet_flying=1; there is no ready, a probe is judged every clock.
   logic                 clear;
   logic                 enable;
   logic [4:0]           bullet_x;
   logic [3:0]           bullet_y;
   logic                 bullet_flying;
   logic                 hit;
   logic [ROWS*COLS-1:0] alive;
   logic [4:0]           fleet_x;
   logic [3:0]           fleet_y;
   logic                 all_dead;
   logic                 invaded;
   logic [1:0]           state_dbg;

   modport master (
      output clear, enable, bullet_x, bullet_y, bullet_flying,
      input  hit, alive, fleet_x, fleet_y, all_dead, invaded, state_dbg
   );

   modport slave (
      input  clear, enable, bullet_x, bullet_y, bullet_flying,
      output hit, alive, fleet_x, fleet_y, all_dead, invaded, state_dbg
   );
endinterface

// File: rtl/alien_fleet.sv
// Invader formation: alive bitmap, marching FSM, bullet collision and wave status.
// Optional FLEET_SPEEDUP_EN shortens the step period as the live alien count drops.
module alien_fleet #(
   parameter int ROWS     = 4,
   parameter int COLS     = 8,
   parameter int MOVE_DIV = 8,
   parameter int FIELD_W  = 32,
   parameter int SHIP_ROW = 15
) (
   input  logic         clk_36MHz,
   input  logic         reset,
   alien_fleet_if.slave bus_io
);
   localparam int N  = ROWS * COLS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(MOVE_DIV + 1);

   typedef enum logic [1:0] {
      MARCH_R = 2'd0,
      MARCH_L = 2'd1,
      WON     = 2'd2,
      LANDED  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   alive_q, alive_d;
   logic [4:0]     fx_q, fx_d;
   logic [3:0]     fy_q, fy_d;
   logic           hit_q, hit_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [5:0]     dx;
   logic [4:0]     dy;
   int             idx;
   logic [IW-1:0]  idx_b;
   logic           marching;
   logic           match;
   logic           step;
   int             period;

`ifdef FLEET_SPEEDUP_EN
   int live;

   always_comb begin
      live = 0;
      for (int i = 0; i < N; i++) begin
         if (alive_q[i]) live = live + 1;
      end
      if (live > N / 2)      period = MOVE_DIV;
      else if (live > N / 4) period = (MOVE_DIV / 2 > 0) ? MOVE_DIV / 2 : 1;
      else                   period = (MOVE_DIV / 4 > 0) ? MOVE_DIV / 4 : 1;
   end
`else
   always_comb period = MOVE_DIV;
`endif

   // Zero-extended differences: a bullet left of / above the fleet sets the top bit instead of wrapping.
   always_comb begin
      dx       = {1'b0, bus_io.bullet_x} - {1'b0, fx_q};
      dy       = {1'b0, bus_io.bullet_y} - {1'b0, fy_q};
      idx      = int'(dy[3:0]) * COLS + int'(dx[4:0]);
      idx_b    = idx[IW-1:0];
      marching = (state_q == MARCH_R) || (state_q == MARCH_L);
      match    = bus_io.bullet_flying && marching && !hit_q &&
                 !dx[5] && (dx[4:0] < 5'(COLS)) &&
                 !dy[4] && (dy[3:0] < 4'(ROWS)) &&
                 alive_q[idx_b];
   end

   always_comb begin
      state_d = state_q;
      alive_d = alive_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      cnt_d   = cnt_q;
      hit_d   = 1'b0;
      step    = 1'b0;
      if (marching) begin
         if (alive_q == '0) begin
            state_d = WON;
         end else begin
            if (match) begin
               hit_d          = 1'b1;
               alive_d[idx_b] = 1'b0;
            end
            if (bus_io.enable) begin
               if (int'(cnt_q) >= period - 1) begin
                  cnt_d = '0;
                  step  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            if (step) begin
               if (state_q == MARCH_R) begin
                  if (int'(fx_q) < FIELD_W - COLS) fx_d = fx_q + 5'd1;
                  else begin
                     fy_d    = fy_q + 4'd1;
                     state_d = MARCH_L;
                  end
               end else begin
                  if (fx_q != 5'd0) fx_d = fx_q - 5'd1;
                  else begin
                     fy_d    = fy_q + 4'd1;
                     state_d = MARCH_R;
                  end
               end
            end
            // A final kill on the landing edge defers to WON on the next cycle.
            if ((int'(fy_d) + ROWS - 1 >= SHIP_ROW) && (alive_d != '0)) state_d = LANDED;
         end
      end
   end

   always_ff @(posedge clk_36MHz) begin
      if (!reset || bus_io.clear) begin
         state_q <= MARCH_R;
         alive_q <= '1;
         fx_q    <= '0;
         fy_q    <= '0;
         hit_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         alive_q <= alive_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         hit_q   <= hit_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus_io.hit       = hit_q;
   assign bus_io.alive     = alive_q;
   assign bus_io.fleet_x   = fx_q;
   assign bus_io.fleet_y   = fy_q;
   assign bus_io.all_dead  = (state_q == WON);
   assign bus_io.invaded   = (state_q == LANDED);
   assign bus_io.state_dbg = state_q;
endmodule

// File: tb/tb_alien_fleet.sv
// Bench for alien_fleet: directed scenarios plus randomized probes against a rule-level fleet model.
// Build with FLEET_SPEEDUP_EN defined to also cover the speed-up periods.
module tb_alien_fleet;
   localparam int ROWS     = 4;
   localparam int COLS     = 8;
   localparam int MOVE_DIV = 8;
   localparam int FIELD_W  = 32;
   localparam int SHIP_ROW = 15;
   localparam int N        = ROWS * COLS;

   logic clk_36MHz;
   logic reset;
   int   checks;
   int   failures;

   alien_fleet_if #(.ROWS(ROWS), .COLS(COLS)) fif ();

   alien_fleet #(
      .ROWS(ROWS), .COLS(COLS), .MOVE_DIV(MOVE_DIV), .FIELD_W(FIELD_W), .SHIP_ROW(SHIP_ROW)
   ) dut (
      .clk_36MHz(clk_36MHz),
      .reset    (reset),
      .bus_io   (fif)
   );

   // ---------------- clock / reset ----------------
   initial clk_36MHz = 1'b0;
   always #14 clk_36MHz = ~clk_36MHz;

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [N-1:0] m_alive;
   int           m_fx, m_fy, m_cnt;
   bit           m_right, m_won, m_landed, m_hit;
   logic         exp_q[$];

   function automatic int model_period(input logic [N-1:0] a);
      int live;
      live = $countones(a);
`ifdef FLEET_SPEEDUP_EN
      if (live > N / 2)      return MOVE_DIV;
      else if (live > N / 4) return (MOVE_DIV / 2 > 0) ? MOVE_DIV / 2 : 1;
      else                   return (MOVE_DIV / 4 > 0) ? MOVE_DIV / 4 : 1;
`else
      if (live < 0) return 1;
      return MOVE_DIV;
`endif
   endfunction

   task automatic model_edge(input bit rst_n, input bit clr, input bit en, input bit bf,
                             input int bx, input int by);
      bit prev_hit;
      int period;
      logic [4:0] ib;
      if (!rst_n || clr) begin
         m_alive = '1; m_fx = 0; m_fy = 0; m_cnt = 0;
         m_right = 1; m_won = 0; m_landed = 0; m_hit = 0;
         return;
      end
      prev_hit = m_hit;
      m_hit    = 0;
      if (m_won || m_landed) return;
      if (m_alive == '0) begin
         m_won = 1;
         return;
      end
      period = model_period(m_alive);
      if (bf && !prev_hit && bx >= m_fx && bx < m_fx + COLS && by >= m_fy && by < m_fy + ROWS) begin
         ib = 5'((by - m_fy) * COLS + (bx - m_fx));
         if (m_alive[ib]) begin
            m_alive[ib] = 1'b0;
            m_hit       = 1;
         end
      end
      if (en) begin
         m_cnt = m_cnt + 1;
         if (m_cnt >= period) begin
            m_cnt = 0;
            if (m_right) begin
               if (m_fx < FIELD_W - COLS) m_fx = m_fx + 1;
               else begin m_fy = m_fy + 1; m_right = 0; end
            end else begin
               if (m_fx > 0) m_fx = m_fx - 1;
               else begin m_fy = m_fy + 1; m_right = 1; end
            end
         end
      end
      if (m_fy + ROWS - 1 >= SHIP_ROW && m_alive != '0) m_landed = 1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input bit clr, input bit en, input bit bf, input int bx, input int by);
      fif.clear         = clr;
      fif.enable        = en;
      fif.bullet_flying = bf;
      fif.bullet_x      = 5'(bx);
      fif.bullet_y      = 4'(by);
      model_edge(reset, clr, en, bf, bx & 31, by & 15);
      @(posedge clk_36MHz);
      #1;
   endtask

   task automatic en_n(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) tick(0, 0, 0, 0, 0);
         tick(0, 1, 0, 0, 0);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      reset = 1'b1;
      tick(0, 0, 0, 0, 0);
      checks++; if (fif.alive !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_alive: got %h expected ffffffff", fif.alive); end
      checks++; if (fif.fleet_x !== 5'd0) begin failures++; $display("FAIL reset_fx: got %0d expected 0", fif.fleet_x); end
      checks++; if (fif.fleet_y !== 4'd0) begin failures++; $display("FAIL reset_fy: got %0d expected 0", fif.fleet_y); end
      checks++; if (fif.hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b expected 0", fif.hit); end
      checks++; if (fif.all_dead !== 1'b0) begin failures++; $display("FAIL reset_all_dead: got %b expected 0", fif.all_dead); end
      checks++; if (fif.invaded !== 1'b0) begin failures++; $display("FAIL reset_invaded: got %b expected 0", fif.invaded); end
   endtask

   task automatic test_march();
      en_n(8);
      checks++; if (fif.fleet_x !== 5'd1) begin failures++; $display("FAIL march_first_step: got %0d expected 1", fif.fleet_x); end
      en_n(7);
      checks++; if (fif.fleet_x !== 5'd1) begin failures++; $display("FAIL march_no_early_step: got %0d expected 1", fif.fleet_x); end
      en_n(1 + 8 * 22);
      checks++; if (fif.fleet_x !== 5'd24) begin failures++; $display("FAIL march_right_edge: got %0d expected 24", fif.fleet_x); end
      en_n(8);
      checks++; if (fif.fleet_x !== 5'd24 || fif.fleet_y !== 4'd1) begin failures++; $display("FAIL march_descend: got x=%0d y=%0d expected x=24 y=1", fif.fleet_x, fif.fleet_y); end
      checks++; if (fif.state_dbg !== 2'd1) begin failures++; $display("FAIL march_state_l: got %0d expected 1", fif.state_dbg); end
      en_n(8);
      checks++; if (fif.fleet_x !== 5'd23 || fif.fleet_y !== 4'd1) begin failures++; $display("FAIL march_left: got x=%0d y=%0d expected x=23 y=1", fif.fleet_x, fif.fleet_y); end
   endtask

   task automatic test_hit();
      tick(1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) exp_q.push_back(k == 0);
      for (int k = 0; k < 5; k++) begin
         tick(0, 0, 1, 3, 2);
         checks++; if (fif.hit !== exp_q[0]) begin failures++; $display("FAIL hit_pulse[%0d]: got %b expected %b", k, fif.hit, exp_q[0]); end
         void'(exp_q.pop_front());
      end
      checks++; if (fif.alive !== 32'hFFF7_FFFF) begin failures++; $display("FAIL hit_alive_bit19: got %h expected fff7ffff", fif.alive); end
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 1, 3, 2);
      checks++; if (fif.hit !== 1'b0) begin failures++; $display("FAIL hit_dead_alien: got %b expected 0", fif.hit); end
   endtask

   task automatic test_no_wrap();
      tick(1, 0, 0, 0, 0);
      en_n(24);
      checks++; if (fif.fleet_x !== 5'd3) begin failures++; $display("FAIL nowrap_fx: got %0d expected 3", fif.fleet_x); end
      tick(0, 0, 1, 2, 5);
      checks++; if (fif.hit !== 1'b0) begin failures++; $display("FAIL nowrap_2_5: got %b expected 0", fif.hit); end
      tick(0, 0, 1, 2, 1);
      checks++; if (fif.hit !== 1'b0) begin failures++; $display("FAIL nowrap_2_1: got %b expected 0", fif.hit); end
      tick(0, 0, 1, 11, 1);
      checks++; if (fif.hit !== 1'b0) begin failures++; $display("FAIL nowrap_right_edge: got %b expected 0", fif.hit); end
      tick(0, 0, 1, 3, 4);
      checks++; if (fif.hit !== 1'b0) begin failures++; $display("FAIL nowrap_bottom_edge: got %b expected 0", fif.hit); end
      tick(0, 0, 1, 10, 3);
      checks++; if (fif.hit !== 1'b1 || fif.alive !== 32'h7FFF_FFFF) begin failures++; $display("FAIL corner_hit: got hit=%b alive=%h expected hit=1 alive=7fffffff", fif.hit, fif.alive); end
   endtask

   task automatic test_hit_and_step();
      tick(1, 0, 0, 0, 0);
      en_n(47);
      checks++; if (fif.fleet_x !== 5'd5) begin failures++; $display("FAIL hs_setup_fx: got %0d expected 5", fif.fleet_x); end
      tick(0, 1, 1, 5, 1);
      checks++; if (fif.hit !== 1'b1) begin failures++; $display("FAIL hs_hit: got %b expected 1", fif.hit); end
      checks++; if (fif.alive !== 32'hFFFF_FEFF) begin failures++; $display("FAIL hs_alive_bit8: got %h expected fffffeff", fif.alive); end
      checks++; if (fif.fleet_x !== 5'd6) begin failures++; $display("FAIL hs_fx: got %0d expected 6", fif.fleet_x); end
   endtask

   task automatic test_all_dead();
      tick(1, 0, 0, 0, 0);
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            tick(0, 0, 1, c, r);
            checks++; if (fif.hit !== 1'b1) begin failures++; $display("FAIL kill_hit(%0d,%0d): got %b expected 1", r, c, fif.hit); end
            if (r == ROWS - 1 && c == COLS - 1) begin
               checks++; if (fif.all_dead !== 1'b0) begin failures++; $display("FAIL all_dead_early: got %b expected 0", fif.all_dead); end
            end
            tick(0, 0, 0, 0, 0);
         end
      end
      checks++; if (fif.all_dead !== 1'b1 || fif.alive !== 32'h0) begin failures++; $display("FAIL all_dead: got %b alive=%h expected 1 alive=0", fif.all_dead, fif.alive); end
      en_n(20);
      checks++; if (fif.fleet_x !== 5'd0 || fif.fleet_y !== 4'd0) begin failures++; $display("FAIL won_frozen: got x=%0d y=%0d expected 0 0", fif.fleet_x, fif.fleet_y); end
   endtask

   task automatic test_invade();
      int guard;
      tick(1, 0, 0, 0, 0);
      guard = 0;
      while (fif.invaded !== 1'b1 && guard < 5000) begin
         tick(0, 1, 0, 0, 0);
         guard++;
      end
      checks++; if (fif.invaded !== 1'b1) begin failures++; $display("FAIL invade_timeout: invaded=%b after %0d enables, expected 1", fif.invaded, guard); end
      checks++; if (fif.fleet_x !== 5'd0 || fif.fleet_y !== 4'd12) begin failures++; $display("FAIL invade_pos: got x=%0d y=%0d expected 0 12", fif.fleet_x, fif.fleet_y); end
      checks++; if (guard !== 300 * MOVE_DIV) begin failures++; $display("FAIL invade_enables: got %0d expected %0d", guard, 300 * MOVE_DIV); end
      en_n(16);
      checks++; if (fif.fleet_x !== 5'd0 || fif.fleet_y !== 4'd12) begin failures++; $display("FAIL landed_frozen: got x=%0d y=%0d expected 0 12", fif.fleet_x, fif.fleet_y); end
      tick(0, 0, 1, 0, 12);
      checks++; if (fif.hit !== 1'b0) begin failures++; $display("FAIL landed_no_hit: got %b expected 0", fif.hit); end
   endtask

   task automatic test_clear();
      tick(1, 0, 0, 0, 0);
      checks++; if (fif.alive !== 32'hFFFF_FFFF || fif.fleet_x !== 5'd0 || fif.fleet_y !== 4'd0) begin failures++; $display("FAIL clear_fleet: got alive=%h x=%0d y=%0d expected ffffffff 0 0", fif.alive, fif.fleet_x, fif.fleet_y); end
      checks++; if (fif.hit !== 1'b0 || fif.all_dead !== 1'b0 || fif.invaded !== 1'b0 || fif.state_dbg !== 2'd0) begin failures++; $display("FAIL clear_flags: got hit=%b dead=%b inv=%b st=%0d expected 0 0 0 0", fif.hit, fif.all_dead, fif.invaded, fif.state_dbg); end
   endtask

`ifdef FLEET_SPEEDUP_EN
   task automatic test_speedup();
      tick(1, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) begin tick(0, 0, 1, i % COLS, i / COLS); tick(0, 0, 0, 0, 0); end
      en_n(3);
      checks++; if (fif.fleet_x !== 5'd0) begin failures++; $display("FAIL speed4_early: got %0d expected 0", fif.fleet_x); end
      en_n(1);
      checks++; if (fif.fleet_x !== 5'd1) begin failures++; $display("FAIL speed4_step: got %0d expected 1", fif.fleet_x); end
      for (int i = 17; i < 25; i++) begin tick(0, 0, 1, 1 + i % COLS, i / COLS); tick(0, 0, 0, 0, 0); end
      en_n(1);
      checks++; if (fif.fleet_x !== 5'd1) begin failures++; $display("FAIL speed2_early: got %0d expected 1", fif.fleet_x); end
      en_n(1);
      checks++; if (fif.fleet_x !== 5'd2) begin failures++; $display("FAIL speed2_step: got %0d expected 2", fif.fleet_x); end
   endtask
`endif

   task automatic test_random();
      logic [N+10:0] got, exp;
      int bx, by;
      tick(1, 0, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) < 7) begin
            bx = (m_fx + $urandom_range(0, COLS)) & 31;
            by = (m_fy + $urandom_range(0, ROWS)) & 15;
         end else begin
            bx = $urandom_range(0, 31);
            by = $urandom_range(0, 15);
         end
         tick($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, bx, by);
         got = {fif.hit, fif.alive, fif.fleet_x, fif.fleet_y, fif.all_dead, fif.invaded};
         exp = {m_hit, m_alive, 5'(m_fx), 4'(m_fy), m_won, m_landed};
         checks++; if (got !== exp) begin failures++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      fif.clear = 1'b0;
      fif.enable = 1'b0;
      fif.bullet_flying = 1'b0;
      fif.bullet_x = '0;
      fif.bullet_y = '0;
      test_reset();
      test_march();
      test_hit();
      test_no_wrap();
      test_hit_and_step();
      test_all_dead();
      test_invade();
      test_clear();
`ifdef FLEET_SPEEDUP_EN
      test_speedup();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
